// File: rtl/ap_add_sequencer_if.sv
// Handshake and CAM control bundle between the instruction controller, the add
// sequencer and the CAM top. The sequencer takes the master side.
interface ap_add_sequencer_if #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 3
);
    logic                  start;
    logic                  carry_in;
    logic                  busy;
    logic                  done;
    logic [CNT_WIDTH-1:0]  bit_idx;
    logic [DATA_WIDTH-1:0] mask_a;
    logic [DATA_WIDTH-1:0] mask_b;
    logic [DATA_WIDTH-1:0] mask_r;
    logic                  key_a;
    logic                  key_b;
    logic                  key_c;
    logic                  mask_c;
    logic                  rst_tag;
    logic                  rst_in_c;
    logic                  cmp_en;
    logic                  wr_en;
    logic [2:0]            pass;
    logic                  wr_r;
    logic                  wr_c;
    logic                  wr_c_en;

    modport master (
        input  start, carry_in,
        output busy, done, bit_idx, mask_a, mask_b, mask_r,
               key_a, key_b, key_c, mask_c, rst_tag, rst_in_c,
               cmp_en, wr_en, pass, wr_r, wr_c, wr_c_en
    );

    modport slave (
        output start, carry_in,
        input  busy, done, bit_idx, mask_a, mask_b, mask_r,
               key_a, key_b, key_c, mask_c, rst_tag, rst_in_c,
               cmp_en, wr_en, pass, wr_r, wr_c, wr_c_en
    );
endinterface

// File: rtl/ap_add_sequencer.sv
// Bit-serial word-parallel adder sequencer: walks each bit column through six
// compare/write passes (CLR, CMP, WR per pass) so the CAM computes R = A + B + Cin.
module ap_add_sequencer #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    ap_add_sequencer_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CLR, S_CMP, S_WR, S_DONE
    } state_t;

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic [CNT_WIDTH-1:0]  bit_idx;
        logic [DATA_WIDTH-1:0] mask_a;
        logic [DATA_WIDTH-1:0] mask_b;
        logic [DATA_WIDTH-1:0] mask_r;
        logic                  key_a;
        logic                  key_b;
        logic                  key_c;
        logic                  mask_c;
        logic                  rst_tag;
        logic                  rst_in_c;
        logic                  cmp_en;
        logic                  wr_en;
        logic [2:0]            pass;
        logic                  wr_r;
        logic                  wr_c;
        logic                  wr_c_en;
    } out_t;

    state_t               state_q, state_d;
    logic [2:0]           p_q, p_d;
    logic [CNT_WIDTH-1:0] bit_q, bit_d;
    logic                 cin_q, cin_d;
    out_t                 out_q, out_d;
    logic [DATA_WIDTH-1:0] onehot;

    assign onehot = DATA_WIDTH'(1) << bit_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        bit_d   = bit_q;
        cin_d   = cin_q;
        out_d   = '0;
        // Outputs describe the state held this cycle, so they trail state_q by one clock.
        out_d.busy    = (state_q != S_IDLE);
        out_d.bit_idx = bit_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_INIT;
                    cin_d   = bus.carry_in;
                end
            end
            S_INIT: begin
                if (cin_q) begin
                    out_d.wr_en   = 1'b1;
                    out_d.pass    = 3'd7;
                    out_d.wr_c    = 1'b1;
                    out_d.wr_c_en = 1'b1;
                end else begin
                    out_d.rst_in_c = 1'b1;
                end
                state_d = S_CLR;
                p_d     = 3'd0;
                bit_d   = '0;
            end
            S_CLR: begin
                out_d.rst_tag = 1'b1;
                state_d       = S_CMP;
            end
            S_CMP: begin
                out_d.cmp_en = 1'b1;
                // Pass 0 leaves every mask clear so all rows tag and get R=0.
                if (p_q != 3'd0) begin
                    out_d.mask_a = onehot;
                    out_d.mask_b = onehot;
                    out_d.mask_c = 1'b1;
                end
                case (p_q)
                    3'd1:    {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b111;
                    3'd2:    {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b110;
                    3'd3:    {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b100;
                    3'd4:    {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b010;
                    3'd5:    {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b001;
                    default: {out_d.key_a, out_d.key_b, out_d.key_c} = 3'b000;
                endcase
                state_d = S_WR;
            end
            S_WR: begin
                out_d.wr_en  = 1'b1;
                out_d.pass   = p_q + 3'd1;
                out_d.mask_r = onehot;
                case (p_q)
                    3'd1:    {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b111;
                    3'd2:    {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b011;
                    3'd3:    {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b100;
                    3'd4:    {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b100;
                    3'd5:    {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b101;
                    default: {out_d.wr_r, out_d.wr_c, out_d.wr_c_en} = 3'b000;
                endcase
                if (p_q == 3'd5) begin
                    p_d = 3'd0;
                    if (bit_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d   = bit_q + CNT_WIDTH'(1);
                        state_d = S_CLR;
                    end
                end else begin
                    p_d     = p_q + 3'd1;
                    state_d = S_CLR;
                end
            end
            S_DONE: begin
                out_d.done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            p_q     <= 3'd0;
            bit_q   <= '0;
            cin_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            bit_q   <= bit_d;
            cin_q   <= cin_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy     = out_q.busy;
    assign bus.done     = out_q.done;
    assign bus.bit_idx  = out_q.bit_idx;
    assign bus.mask_a   = out_q.mask_a;
    assign bus.mask_b   = out_q.mask_b;
    assign bus.mask_r   = out_q.mask_r;
    assign bus.key_a    = out_q.key_a;
    assign bus.key_b    = out_q.key_b;
    assign bus.key_c    = out_q.key_c;
    assign bus.mask_c   = out_q.mask_c;
    assign bus.rst_tag  = out_q.rst_tag;
    assign bus.rst_in_c = out_q.rst_in_c;
    assign bus.cmp_en   = out_q.cmp_en;
    assign bus.wr_en    = out_q.wr_en;
    assign bus.pass     = out_q.pass;
    assign bus.wr_r     = out_q.wr_r;
    assign bus.wr_c     = out_q.wr_c;
    assign bus.wr_c_en  = out_q.wr_c_en;
endmodule

// File: tb/tb_ap_add_sequencer.sv
// Directed bench for ap_add_sequencer with a three-row behavioural CAM attached,
// checking strobe timing, pass contents and end-to-end addition results.
module tb_ap_add_sequencer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    ap_add_sequencer_if #(.DATA_WIDTH(4), .CNT_WIDTH(3)) bus ();

    ap_add_sequencer #(.DATA_WIDTH(4), .CNT_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] all_out;
    assign all_out = {bus.busy, bus.done, bus.bit_idx, bus.mask_a, bus.mask_b, bus.mask_r,
                      bus.key_a, bus.key_b, bus.key_c, bus.mask_c, bus.rst_tag, bus.rst_in_c,
                      bus.cmp_en, bus.wr_en, bus.pass, bus.wr_r, bus.wr_c, bus.wr_c_en};

    // Behavioural CAM: three rows of A, B (loaded by the stimulus), R, C and a tag.
    logic [3:0] ra [3];
    logic [3:0] rb [3];
    logic [3:0] rr [3];
    logic       rc [3];
    logic       rt [3];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                rr[i] = 4'hA;
                rc[i] = 1'b0;
                rt[i] = 1'b0;
            end
        end else begin
            if (bus.rst_in_c) for (int i = 0; i < 3; i++) rc[i] = 1'b0;
            if (bus.rst_tag)  for (int i = 0; i < 3; i++) rt[i] = 1'b0;
            if (bus.cmp_en) begin
                for (int i = 0; i < 3; i++)
                    rt[i] = ((ra[i] & bus.mask_a) == ({4{bus.key_a}} & bus.mask_a)) &&
                            ((rb[i] & bus.mask_b) == ({4{bus.key_b}} & bus.mask_b)) &&
                            (!bus.mask_c || (rc[i] == bus.key_c));
            end
            if (bus.wr_en) begin
                if (bus.pass == 3'd7) begin
                    for (int i = 0; i < 3; i++) rc[i] = bus.wr_c;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (rt[i]) begin
                            rr[i] = (rr[i] & ~bus.mask_r) | (bus.wr_r ? bus.mask_r : 4'h0);
                            if (bus.wr_c_en) rc[i] = bus.wr_c;
                        end
                    end
                end
            end
        end
    end

    // Raises start for the edge that the caller counts as cycle 0.
    task automatic start_run(input logic cin);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.carry_in = cin;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.carry_in = 1'b0;
    endtask

    // Returns the cycle index of the first done pulse, or -1 if none within the budget.
    task automatic wait_done(input int first_k, output int done_k);
        done_k = -1;
        for (int k = first_k; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_k = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (all_out !== 33'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.busy !== 1'b0 || bus.bit_idx !== 3'd0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b bit_idx=%0d expected busy=0 bit_idx=0", bus.busy, bus.bit_idx);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic_run;
        int cmp_cnt, wr_cnt, done_at, done_cnt, bad;
        logic [2:0] seq [$];
        cmp_cnt = 0; wr_cnt = 0; done_at = -1; done_cnt = 0;
        start_run(1'b0);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            if (bus.cmp_en) cmp_cnt++;
            if (bus.wr_en) begin
                wr_cnt++;
                seq.push_back(bus.pass);
            end
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == 1) begin
                tests++;
                if (bus.rst_in_c !== 1'b1 || bus.busy !== 1'b1 || bus.wr_en !== 1'b0) begin
                    fails++;
                    $display("FAIL init_cin0: rst_in_c=%b busy=%b wr_en=%b expected 1 1 0",
                             bus.rst_in_c, bus.busy, bus.wr_en);
                end
            end
            if (k == 45) begin
                tests++;
                if ({bus.cmp_en, bus.mask_a, bus.mask_b, bus.key_a, bus.key_b, bus.key_c, bus.mask_c, bus.bit_idx}
                    !== {1'b1, 4'b0100, 4'b0100, 3'b110, 1'b1, 3'd2}) begin
                    fails++;
                    $display("FAIL p2_cmp_bit2: cmp=%b ma=%b mb=%b key=%b%b%b mc=%b bit=%0d expected 1 0100 0100 110 1 2",
                             bus.cmp_en, bus.mask_a, bus.mask_b, bus.key_a, bus.key_b, bus.key_c, bus.mask_c, bus.bit_idx);
                end
            end
            if (k == 46) begin
                tests++;
                if ({bus.wr_en, bus.wr_r, bus.wr_c, bus.wr_c_en, bus.mask_r, bus.pass}
                    !== {1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 3'd3}) begin
                    fails++;
                    $display("FAIL p2_wr_bit2: wr=%b r=%b c=%b cen=%b mr=%b pass=%0d expected 1 0 1 1 0100 3",
                             bus.wr_en, bus.wr_r, bus.wr_c, bus.wr_c_en, bus.mask_r, bus.pass);
                end
            end
            if (k == 76) begin
                tests++;
                if (bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_done: got %b expected 0", bus.busy);
                end
            end
        end
        tests++;
        if (done_at != 74 || done_cnt != 1) begin
            fails++;
            $display("FAIL done_timing: at=%0d count=%0d expected at=74 count=1", done_at, done_cnt);
        end
        tests++;
        if (cmp_cnt != 24 || wr_cnt != 24) begin
            fails++;
            $display("FAIL strobe_counts: cmp=%0d wr=%0d expected 24 24", cmp_cnt, wr_cnt);
        end
        bad = (seq.size() != 24) ? 1 : 0;
        for (int i = 0; i < seq.size(); i++)
            if (seq[i] != 3'((i % 6) + 1)) bad = 1;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL pass_sequence: size=%0d expected 24 entries of 1..6 repeated", seq.size());
        end
        $display("[TB] test_basic_run done_at=%0d cmp=%0d wr=%0d", done_at, cmp_cnt, wr_cnt);
    endtask

    task automatic test_carry_init;
        int dk;
        start_run(1'b1);
        @(posedge clk);
        #1;
        tests++;
        if ({bus.wr_en, bus.pass, bus.wr_c, bus.wr_c_en, bus.rst_in_c, bus.mask_r, bus.mask_a, bus.mask_b}
            !== {1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 12'd0}) begin
            fails++;
            $display("FAIL init_cin1: wr=%b pass=%0d wr_c=%b cen=%b rst_in_c=%b masks=%b%b%b expected 1 7 1 1 0 zeros",
                     bus.wr_en, bus.pass, bus.wr_c, bus.wr_c_en, bus.rst_in_c, bus.mask_r, bus.mask_a, bus.mask_b);
        end
        wait_done(2, dk);
        tests++;
        if (dk != 74) begin
            fails++;
            $display("FAIL done_cin1: got %0d expected 74", dk);
        end
        $display("[TB] test_carry_init done_at=%0d", dk);
    endtask

    task automatic test_start_while_busy;
        int done_at, done_cnt, extra;
        done_at = -1; done_cnt = 0; extra = 0;
        start_run(1'b0);
        for (int k = 1; k <= 110; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == 19);
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k > 76 && (bus.busy || bus.cmp_en || bus.wr_en || bus.rst_tag || bus.rst_in_c)) extra++;
        end
        tests++;
        if (done_at != 74 || done_cnt != 1) begin
            fails++;
            $display("FAIL busy_start_done: at=%0d count=%0d expected 74 1", done_at, done_cnt);
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL busy_start_no_rerun: active cycles=%0d expected 0", extra);
        end
        $display("[TB] test_start_while_busy done_at=%0d", done_at);
    endtask

    task automatic test_reset_midrun;
        int active;
        active = 0;
        start_run(1'b0);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (all_out !== 33'd0) begin
            fails++;
            $display("FAIL midrun_reset_outputs: got %h expected 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy || bus.cmp_en || bus.wr_en || bus.rst_tag || bus.done) active++;
        end
        tests++;
        if (active != 0 || bus.bit_idx !== 3'd0) begin
            fails++;
            $display("FAIL midrun_reset_idle: active=%0d bit_idx=%0d expected 0 0", active, bus.bit_idx);
        end
        $display("[TB] test_reset_midrun");
    endtask

    task automatic test_cam_add;
        int dk;
        ra[0] = 4'd9;  rb[0] = 4'd7;
        ra[1] = 4'd3;  rb[1] = 4'd4;
        ra[2] = 4'd15; rb[2] = 4'd15;
        start_run(1'b0);
        wait_done(1, dk);
        @(negedge clk);
        tests++;
        if (dk < 0 || rr[0] !== 4'd0 || rc[0] !== 1'b1) begin
            fails++;
            $display("FAIL add_9_7: R=%0d C=%b expected R=0 C=1", rr[0], rc[0]);
        end
        tests++;
        if (rr[1] !== 4'd7 || rc[1] !== 1'b0) begin
            fails++;
            $display("FAIL add_3_4: R=%0d C=%b expected R=7 C=0", rr[1], rc[1]);
        end
        tests++;
        if (rr[2] !== 4'd14 || rc[2] !== 1'b1) begin
            fails++;
            $display("FAIL add_15_15: R=%0d C=%b expected R=14 C=1", rr[2], rc[2]);
        end
        $display("[TB] test_cam_add cin=0 R=%0d,%0d,%0d", rr[0], rr[1], rr[2]);

        start_run(1'b1);
        wait_done(1, dk);
        @(negedge clk);
        tests++;
        if (dk < 0 || rr[1] !== 4'd8 || rc[1] !== 1'b0) begin
            fails++;
            $display("FAIL add_3_4_c1: R=%0d C=%b expected R=8 C=0", rr[1], rc[1]);
        end
        tests++;
        if (rr[0] !== 4'd1 || rc[0] !== 1'b1) begin
            fails++;
            $display("FAIL add_9_7_c1: R=%0d C=%b expected R=1 C=1", rr[0], rc[0]);
        end
        tests++;
        if (rr[2] !== 4'd15 || rc[2] !== 1'b1) begin
            fails++;
            $display("FAIL add_15_15_c1: R=%0d C=%b expected R=15 C=1", rr[2], rc[2]);
        end
        $display("[TB] test_cam_add cin=1 R=%0d,%0d,%0d", rr[0], rr[1], rr[2]);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        bus.start    = 1'b0;
        bus.carry_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = 4'd0;
            rb[i] = 4'd0;
        end
        test_reset();
        test_basic_run();
        test_carry_init();
        test_start_while_busy();
        test_reset_midrun();
        test_cam_add();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ap_add_sequencer.md
Name: ap_add_sequencer

Overview:
- Initiator-side control sequencer for the CAM array.
- Drives the compare/write pass protocol (masks, keys, tag reset, pass codes) to perform word-parallel bit-serial addition R = A + B + carry_in across all rows.
- Sits between the instruction controller and the CAM top; one start request runs one full DATA_WIDTH-bit add.

Parameters:
DATA_WIDTH, 4, word width; number of bit columns processed
CNT_WIDTH, 3, width of bit-index counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request one add; sampled only in IDLE
carry_in  input  1  initial carry for all rows, sampled with start
busy  output  1  high from cycle after start accepted until DONE exits
done  output  1  one-cycle pulse at completion
bit_idx  output  CNT_WIDTH  current bit column
mask_a  output  DATA_WIDTH  one-hot compare mask for A column, 0 when unused
mask_b  output  DATA_WIDTH  one-hot compare mask for B column
mask_r  output  DATA_WIDTH  one-hot write mask for R column
key_a  output  1  compare key, A bit
key_b  output  1  compare key, B bit
key_c  output  1  compare key, carry bit
mask_c  output  1  carry included in compare
rst_tag  output  1  clears tag register
rst_in_c  output  1  clears carry column
cmp_en  output  1  compare cycle strobe
wr_en  output  1  write cycle strobe
pass  output  3  write pass code; 0 outside write cycles
wr_r  output  1  value written to R in tagged rows
wr_c  output  1  value written to C in tagged rows
wr_c_en  output  1  C column written this pass

Behaviour:
- Reset (async, rst_n=0): state IDLE, bit_idx=0, all outputs 0.
- Outputs are registered; all strobes are single-cycle.
- States: IDLE, INIT, CLR, CMP, WR, DONE. Internal pass counter p runs 0..5.
- IDLE:
  - start=1 goes to INIT; carry_in is latched.
  - start during any other state is ignored (not queued).
- INIT (1 cycle):
  - carry_in=0: rst_in_c=1.
  - carry_in=1: wr_en=1, pass=7, wr_c=1, wr_c_en=1, all masks 0.
  - Next state CLR, p=0, bit_idx=0.
- Per pass, three cycles:
  - CLR: rst_tag=1.
  - CMP: cmp_en=1; masks/keys per table.
  - WR: wr_en=1, pass=p+1, mask_r=one-hot(bit_idx), wr_r/wr_c/wr_c_en per table.
- Pass table; key is (A,B,C), result is R,C:
  - p0: no compare (mask_a=mask_b=0, mask_c=0, all rows tag) -> R=0, C untouched.
  - p1: 111 -> R1 C1.
  - p2: 110 -> R0 C1.
  - p3: 100 -> R1.
  - p4: 010 -> R1.
  - p5: 001 -> R1 C0.
  - Passes p1..p5 use mask_a=mask_b=one-hot(bit_idx) and mask_c=1.
  - Order is mandatory: rows rewritten by p2 become 111 and p5 rows become 000, so neither rematches a later key. Rows 000/011/101 keep R=0 from p0, and their C is already correct.
- After WR of p5:
  - If bit_idx==DATA_WIDTH-1, go to DONE.
  - Else bit_idx+1, p=0, go to CLR.
- DONE (1 cycle): done=1, busy=0 on exit; back to IDLE. bit_idx holds DATA_WIDTH-1 until next INIT.
- Latency: 18 cycles per bit. done is asserted exactly 2+18*DATA_WIDTH cycles after the start-sampling edge (74 for DATA_WIDTH=4).
- Final carry-out is left in the C column.
- Reset mid-operation aborts immediately; no partial strobes after rst_n falls.

Test Plan:
- Reset then idle: rst_n low mid-run at cycle 30 -> all outputs 0 in the same cycle; after release stays IDLE with busy=0.
- start=1, carry_in=0, W=4 -> rst_in_c pulse at cycle 1; done pulse exactly at cycle 74; cmp_en count=24, wr_en count=24, pass sequence 1..6 repeated 4 times.
- Pass content at bit_idx=2: the p2 compare cycle shows mask_a=mask_b=4'b0100, key (1,1,0), mask_c=1; its WR shows wr_r=0, wr_c=1, wr_c_en=1, mask_r=4'b0100.
- carry_in=1 -> INIT shows wr_en=1, pass=7, wr_c=1, rst_in_c=0.
- Start while busy at cycle 20 -> ignored; done still at cycle 74; no second run.
- With the CAM model attached, rows A=9,B=7,C0=0 -> R=0, carry=1; A=3,B=4,carry_in=1 -> R=8, carry=0; A=15,B=15 -> R=14, carry=1.
